// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dmem_responder                                             |
// | Description : Handshaked RV32I data-memory target. Decodes funct3 width  |
// |               and signedness, merges store byte lanes, extends load     |
// |               data and flags misaligned, out-of-range and illegal       |
// |               accesses after a programmable fixed latency.              |
// | Options     : DMEM_RESP_BACKTOBACK_EN - accept a new request on the      |
// |               same edge that a response completes.                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dmem_responder #(
    parameter int MEM_WORDS = 512,
    parameter int LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         c_IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_WAIT   = 2'd1;
    localparam logic [1:0] c_ST_RESP   = 2'd2;
    localparam logic [3:0] c_WAIT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic [1:0] c_SZ_BYTE   = 2'd0;
    localparam logic [1:0] c_SZ_HALF   = 2'd1;
    localparam logic [1:0] c_SZ_WORD   = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [2:0]  r_funct3;
    logic [31:0] r_wdata;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic [31:0] r_mem [MEM_WORDS];

    logic               w_req_fire;
    logic               w_use_cap;
    logic               w_acc_we;
    logic [31:0]        w_acc_addr;
    logic [2:0]         w_acc_funct3;
    logic [31:0]        w_acc_wdata;
    logic [1:0]         w_lane;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_oor;
    logic               w_f3_bad;
    logic [1:0]         w_size;
    logic               w_misal;
    logic               w_err;
    logic [31:0]        w_word;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_ld_ext;
    logic [31:0]        w_rdata;
    logic [3:0]         w_be;
    logic [31:0]        w_wd;
    logic               w_enter_resp;
    logic               w_commit;

`ifdef DMEM_RESP_BACKTOBACK_EN
    // A completing response frees the slot, so a new request may overlap it.
    assign req_ready = (r_state == c_ST_IDLE) | ((r_state == c_ST_RESP) & rsp_ready);
`else
    assign req_ready = (r_state == c_ST_IDLE);
`endif

    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_err    = r_rsp_err;
    assign w_req_fire = req_valid & req_ready;

    // In WAIT the access comes from the captured request; otherwise the access
    // is performed on the handshake edge itself (LATENCY=1), so use the inputs.
    assign w_use_cap    = (r_state == c_ST_WAIT);
    assign w_acc_we     = w_use_cap ? r_we     : req_we;
    assign w_acc_addr   = w_use_cap ? r_addr   : req_addr;
    assign w_acc_funct3 = w_use_cap ? r_funct3 : req_funct3;
    assign w_acc_wdata  = w_use_cap ? r_wdata  : req_wdata;

    assign w_lane  = w_acc_addr[1:0];
    assign w_idx   = w_acc_addr[c_IDX_W+1:2];
    assign w_oor   = (w_acc_addr[31:2] >= 30'(MEM_WORDS));
    assign w_misal = ((w_size == c_SZ_HALF) & w_acc_addr[0]) |
                     ((w_size == c_SZ_WORD) & (w_acc_addr[1:0] != 2'b00));
    assign w_err   = w_f3_bad | w_misal | w_oor;

    // Width decode; unsigned variants are only legal for loads.
    always_comb begin
        w_f3_bad = 1'b0;
        w_size   = c_SZ_BYTE;
        case (w_acc_funct3)
            3'b000:  w_size = c_SZ_BYTE;
            3'b001:  w_size = c_SZ_HALF;
            3'b010:  w_size = c_SZ_WORD;
            3'b100: begin
                w_size   = c_SZ_BYTE;
                w_f3_bad = w_acc_we;
            end
            3'b101: begin
                w_size   = c_SZ_HALF;
                w_f3_bad = w_acc_we;
            end
            default: w_f3_bad = 1'b1;
        endcase
    end

    // Lane selection and sign/zero extension of the addressed load data.
    always_comb begin
        w_word   = w_oor ? 32'd0 : r_mem[w_idx];
        w_byte   = w_word[7:0];
        case (w_lane)
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        w_half   = w_acc_addr[1] ? w_word[31:16] : w_word[15:0];
        w_ld_ext = 32'd0;
        case (w_acc_funct3)
            3'b000:  w_ld_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ld_ext = {24'd0, w_byte};
            3'b001:  w_ld_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_ld_ext = {16'd0, w_half};
            3'b010:  w_ld_ext = w_word;
            default: w_ld_ext = 32'd0;
        endcase
        w_rdata  = (w_acc_we | w_err) ? 32'd0 : w_ld_ext;
    end

    // Store byte enables with the right-aligned data replicated onto every lane.
    always_comb begin
        w_be = 4'b0000;
        w_wd = w_acc_wdata;
        case (w_size)
            c_SZ_BYTE: begin
                w_be = 4'b0001 << w_lane;
                w_wd = {4{w_acc_wdata[7:0]}};
            end
            c_SZ_HALF: begin
                w_be = w_acc_addr[1] ? 4'b1100 : 4'b0011;
                w_wd = {2{w_acc_wdata[15:0]}};
            end
            c_SZ_WORD: w_be = 4'b1111;
            default:   w_be = 4'b0000;
        endcase
    end

    // Entering RESP is the single commit point; reset on that edge cancels it.
    assign w_enter_resp = ((r_state == c_ST_WAIT) & (r_cnt == 4'd0)) |
                          (w_req_fire & (LATENCY == 1));
    assign w_commit     = w_enter_resp & w_acc_we & ~w_err & ~rst;

    // Storage array: byte-lane writes only, contents survive reset.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
                end
            end
        end
    end

    // Request/response sequencing with registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_addr      <= 32'd0;
            r_funct3    <= 3'd0;
            r_wdata     <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: ;
                c_ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= c_ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_rdata;
                        r_rsp_err   <= w_err;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_ST_RESP: begin
                    if (r_rsp_valid & rsp_ready) begin
                        r_state     <= c_ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_rdata <= 32'd0;
                        r_rsp_err   <= 1'b0;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
            // A request can only fire in IDLE or in a completing RESP, so this
            // acceptance overrides the case above where both apply.
            if (w_req_fire) begin
                r_we     <= req_we;
                r_addr   <= req_addr;
                r_funct3 <= req_funct3;
                r_wdata  <= req_wdata;
                if (LATENCY == 1) begin
                    r_state     <= c_ST_RESP;
                    r_rsp_valid <= 1'b1;
                    r_rsp_rdata <= w_rdata;
                    r_rsp_err   <= w_err;
                end else begin
                    r_state <= c_ST_WAIT;
                    r_cnt   <= c_WAIT_INIT;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Handshaked data-memory target that serves the load/store requests issued by the multi-cycle RV32I core's memory-access stage.
- It replaces the current zero-wait memory so that the core's MA stage can be changed to stall on real memory latency.
- It decodes RV32I funct3 access width and signedness, performs byte-lane merging for stores and sign/zero extension for loads, and flags misaligned, out-of-range and illegal accesses.

Parameters:
MEM_WORDS, 512, number of 32-bit words; valid byte addresses are 0 to 4*MEM_WORDS-1.
LATENCY, 2, cycles from request acceptance to rsp_valid; legal range 1 to 15.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  responder can accept a request.
req_we  input  1  1 = store, 0 = load.
req_addr  input  32  byte address.
req_funct3  input  3  RV32I funct3 of the load/store.
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
rsp_valid  output  1  response present.
rsp_ready  input  1  initiator accepts the response.
rsp_rdata  output  32  load result after extension; 0 for stores and errors.
rsp_err  output  1  access error.

Behaviour:
- Reset state: state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, internal counter=0. req_ready is 1 in the cycle after rst deasserts.
- Memory array contents are not cleared by rst. Simulation initial contents are all zero.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE: req_ready=1.
  - A handshake (req_valid & req_ready) at edge T captures we, addr, funct3 and wdata.
  - If LATENCY=1, go to RESP. Otherwise go to WAIT with counter=LATENCY-2.
  - Captured values stay stable until the response completes. Inputs are ignored outside the handshake.
- WAIT: req_ready=0. Counter decrements each cycle. When the counter is 0, go to RESP.
- On entry to RESP (the transition edge) the access is performed:
  - Store: write the enabled byte lanes. This is the only commit point.
  - Load: register the extended data into rsp_rdata.
  - rsp_valid rises at T+LATENCY.
- RESP: rsp_valid=1, req_ready=0.
  - rsp_rdata and rsp_err hold stable until rsp_valid & rsp_ready.
  - Then go to IDLE and clear rsp_valid on that edge.
- Byte order is little-endian. Word index is addr[31:2]; lane is addr[1:0].
- Loads:
  - funct3 000 LB: sign-extend.
  - funct3 100 LBU: zero-extend.
  - funct3 001 LH: sign-extend 16 bits.
  - funct3 101 LHU: zero-extend 16 bits.
  - funct3 010 LW.
- Stores:
  - funct3 000 SB: one lane = wdata[7:0].
  - funct3 001 SH: lanes {addr[1],0} and {addr[1],1} = wdata[15:0].
  - funct3 010 SW: all lanes.
- Error (rsp_err=1, rsp_rdata=0, no write) on any of:
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:2] >= MEM_WORDS;
  - load funct3 of 011, 110 or 111;
  - store funct3 with bit 2 set or equal to 011.
- An errored access still completes the full handshake with normal latency.
- Reset asserted in WAIT or RESP: the pending access is dropped and the FSM returns to IDLE. A store reset while in WAIT is never written. A store reset while in RESP has already been written.
- A load following a store sees the stored data. There are no stale reads.

Optional Feature:
- Macro: DMEM_RESP_BACKTOBACK_EN.
- Defined:
  - In RESP, req_ready = rsp_ready.
  - A response handshake and a new request handshake may occur on the same edge, going to WAIT or to RESP per LATENCY.
  - Throughput is one access per LATENCY cycles.
- Undefined:
  - req_ready=0 in RESP, so there is one mandatory IDLE cycle between accesses.
  - Throughput is one access per LATENCY+1 cycles.

Test Plan:
- SW wdata=0x800000F1 addr=0x10, then LB 0x10, LBU 0x13, LH 0x12 -> rdata 0xFFFFFFF1, 0x00000080, 0xFFFF8000; rsp_err=0 on all.
- After the test above, SB wdata=0x1234565A addr=0x11, then LW 0x10 -> 0x80005AF1; SH wdata=0xBEEF addr=0x12, then LHU 0x12 -> 0x0000BEEF.
- LATENCY=3, handshake at cycle 10 -> rsp_valid first at cycle 13. Hold rsp_ready=0 for 4 cycles -> rsp_valid/rsp_rdata stable and req_ready=0 throughout.
- LW addr=0x06, SH addr=0x21, LW addr=0x800 (MEM_WORDS=512), load funct3=011 -> rsp_err=1, rdata=0; a follow-up LW 0x04 shows memory unchanged.
- SW 0xDEADBEEF to 0x40 with rst pulsed while in WAIT (LATENCY=4), then LW 0x40 -> old value 0x00000000; idle outputs return to their reset values.
- With DMEM_RESP_BACKTOBACK_EN, LATENCY=1, rsp_ready=1 and 4 queued loads -> a response every cycle. Without the macro -> a response every 2 cycles.
